// File: rtl/spi_angle_poller.sv
// Round-robin SPI master polling NUM_SENSORS 14-bit angle encoders (16-bit frames, even parity).
// Per-sensor angle/valid/error/update-count and a control register are exposed over Avalon-MM.
module spi_angle_poller #(
  parameter int          NUM_SENSORS = 8,
  parameter int          CLK_DIV     = 25,
  parameter int          CS_SETUP    = 4,
  parameter int          IDLE_CYCLES = 8,
  parameter logic [15:0] CMD_WORD    = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             avs_address,
  input  logic                   avs_read,
  output logic [31:0]            avs_readdata,
  input  logic                   avs_write,
  input  logic [31:0]            avs_writedata,
  output logic                   angle_sck,
  output logic                   angle_mosi,
  input  logic                   angle_miso,
  output logic [NUM_SENSORS-1:0] angle_ss_n_o
);

  localparam int         IDX_W     = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int         CNT_W     = 16;
  localparam logic [4:0] CTRL_ADDR = 5'd16;

  typedef enum logic [1:0] {IDLE, SELECT, SHIFT, DESELECT} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [3:0]             bit_cnt;
  logic [15:0]            shift_reg;
  logic [IDX_W-1:0]       cur_idx;
  logic [IDX_W-1:0]       next_idx;
  int                     cand;
  logic                   enable;
  logic [NUM_SENSORS-1:0] mask;
  logic                   miso_meta;
  logic                   miso_sync;
  logic [13:0]            angle [NUM_SENSORS];
  logic [7:0]             update_count [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] valid;
  logic [NUM_SENSORS-1:0] error;
  logic                   frame_ok;
  logic                   commit;
  logic [31:0]            read_mux;
  logic                   unused_wdata;

  assign unused_wdata = ^avs_writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miso_meta <= 1'b1;
      miso_sync <= 1'b1;
    end else begin
      miso_meta <= angle_miso;
      miso_sync <= miso_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable <= 1'b0;
      mask   <= '0;
    end else if (avs_write && (avs_address == CTRL_ADDR)) begin
      enable <= avs_writedata[0];
      mask   <= avs_writedata[16 +: NUM_SENSORS];
    end
  end

  // Scan from the largest offset down so the nearest masked sensor after cur_idx wins.
  always_comb begin
    next_idx = cur_idx;
    cand     = 0;
    for (int k = NUM_SENSORS; k >= 1; k--) begin
      cand = int'(cur_idx) + k;
      if (cand >= NUM_SENSORS) cand = cand - NUM_SENSORS;
      if (mask[cand[IDX_W-1:0]]) next_idx = cand[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      cur_idx      <= IDX_W'(NUM_SENSORS - 1);
      angle_sck    <= 1'b0;
      angle_mosi   <= 1'b1;
      angle_ss_n_o <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (enable && (|mask)) begin
            state   <= SELECT;
            cur_idx <= next_idx;
            cnt     <= '0;
            for (int i = 0; i < NUM_SENSORS; i++)
              angle_ss_n_o[i] <= (IDX_W'(i) != next_idx);
          end
        end
        SELECT: begin
          if (cnt == CNT_W'(CS_SETUP - 1)) begin
            state      <= SHIFT;
            cnt        <= '0;
            bit_cnt    <= '0;
            angle_sck  <= 1'b1;
            angle_mosi <= CMD_WORD[15];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // CPHA=1: MOSI changes on the rising edge, MISO is captured on the falling edge.
        SHIFT: begin
          if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt <= '0;
            if (angle_sck) begin
              angle_sck <= 1'b0;
              shift_reg <= {shift_reg[14:0], miso_sync};
            end else if (bit_cnt == 4'd15) begin
              state        <= DESELECT;
              angle_ss_n_o <= '1;
              angle_mosi   <= 1'b1;
            end else begin
              angle_sck  <= 1'b1;
              bit_cnt    <= bit_cnt + 4'd1;
              angle_mosi <= CMD_WORD[4'd14 - bit_cnt];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DESELECT: begin
          if (cnt == CNT_W'(IDLE_CYCLES - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign frame_ok = (~^shift_reg) && !shift_reg[14];
  assign commit   = (state == DESELECT) && (cnt == '0);

  // A rejected frame only raises error; the last good angle and count survive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      error <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        angle[i]        <= '0;
        update_count[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (IDX_W'(i) == cur_idx) begin
          if (frame_ok) begin
            angle[i]        <= shift_reg[13:0];
            valid[i]        <= 1'b1;
            error[i]        <= 1'b0;
            update_count[i] <= update_count[i] + 8'd1;
          end else begin
            error[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    read_mux = '0;
    if (avs_address == CTRL_ADDR) begin
      read_mux[0]                   = enable;
      read_mux[16 +: NUM_SENSORS]   = mask;
    end else if (int'(avs_address) < NUM_SENSORS) begin
      read_mux = {update_count[avs_address[IDX_W-1:0]], 6'b0,
                  error[avs_address[IDX_W-1:0]], valid[avs_address[IDX_W-1:0]],
                  2'b0, angle[avs_address[IDX_W-1:0]]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         avs_readdata <= '0;
    else if (avs_read) avs_readdata <= read_mux;
  end

endmodule

// File: tb/tb_spi_angle_poller.sv
// Self-checking bench for spi_angle_poller: SPI sensor model, frame monitor and register scoreboard.
`timescale 1ns/1ps
module tb_spi_angle_poller;

  localparam logic [15:0] CMD = 16'hA5C3;
  localparam int FRAME_LOW = 4 + 32 * 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        angle_sck;
  logic        angle_mosi;
  logic        angle_miso = 1'b1;
  logic [7:0]  angle_ss_n_o;

  int errors = 0;
  int checks = 0;

  logic [15:0] resp [8];
  int          sel_log [$];
  int          len_log [$];
  logic [15:0] mosi_log [$];
  int          exp_sel [$];
  logic [31:0] exp_reg [$];
  int          frame_count = 0;
  int          start_count = 0;

  logic [13:0] m_angle [8];
  logic        m_valid [8];
  logic        m_err [8];
  logic [7:0]  m_cnt [8];

  bit          in_frame = 1'b0;
  int          low_cnt = 0;
  int          mon_lows;
  int          mon_idx;
  logic [15:0] mdl_word = '0;
  logic [15:0] mosi_sh = '0;
  int          drv_start = 0;
  int          drv_bit = 0;

  spi_angle_poller #(
    .NUM_SENSORS(8), .CLK_DIV(4), .CS_SETUP(4), .IDLE_CYCLES(8), .CMD_WORD(CMD)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_write(avs_write), .avs_writedata(avs_writedata),
    .angle_sck(angle_sck), .angle_mosi(angle_mosi), .angle_miso(angle_miso),
    .angle_ss_n_o(angle_ss_n_o)
  );

  always #5 clk = ~clk;

  // Frame monitor: records selected sensor, select-low length and MOSI word of each frame.
  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
    end else if (angle_ss_n_o != 8'hFF) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        low_cnt  = 0;
        mon_lows = 0;
        mon_idx  = 99;
        for (int i = 0; i < 8; i++)
          if (!angle_ss_n_o[i]) begin mon_lows++; mon_idx = i; end
        if (mon_lows != 1) mon_idx = 99;
        sel_log.push_back(mon_idx);
        if (mon_idx < 8) mdl_word = resp[mon_idx];
        else mdl_word = 16'h0000;
        start_count++;
      end
      low_cnt++;
    end else if (in_frame) begin
      in_frame = 1'b0;
      len_log.push_back(low_cnt);
      mosi_log.push_back(mosi_sh);
      frame_count++;
    end
  end

  // Sensor model: shifts its response out MSB first on each SCK rising edge.
  always @(posedge angle_sck) begin
    #1;
    if (drv_start != start_count) begin
      drv_start = start_count;
      drv_bit   = 0;
    end
    if (drv_bit < 16) angle_miso = mdl_word[15 - drv_bit];
    drv_bit++;
  end

  always @(negedge angle_sck) mosi_sh = {mosi_sh[14:0], angle_mosi};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got unfinished run, required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] model_word(input int idx);
    return {m_cnt[idx], 6'b0, m_err[idx], m_valid[idx], 2'b0, m_angle[idx]};
  endfunction

  function automatic logic [31:0] model_commit(input int idx, input logic [15:0] f);
    if (((^f) == 1'b0) && (f[14] == 1'b0)) begin
      m_angle[idx] = f[13:0];
      m_valid[idx] = 1'b1;
      m_err[idx]   = 1'b0;
      m_cnt[idx]   = m_cnt[idx] + 8'd1;
    end else begin
      m_err[idx] = 1'b1;
    end
    return model_word(idx);
  endfunction

  task automatic clear_logs();
    sel_log.delete();
    len_log.delete();
    mosi_log.delete();
    exp_sel.delete();
    exp_reg.delete();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_angle[i] = '0; m_valid[i] = 1'b0; m_err[i] = 1'b0; m_cnt[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    clear_logs();
    @(negedge clk);
  endtask

  task automatic avs_wr(input logic [4:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [4:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    d = avs_readdata;
    avs_read = 1'b0;
  endtask

  task automatic run_frames(input logic [31:0] ctrl, input int n);
    int base;
    int budget;
    base = frame_count;
    budget = 0;
    avs_wr(5'd16, ctrl);
    while ((frame_count < base + n) && (budget < n * 200 + 200)) begin
      @(negedge clk);
      budget++;
    end
    avs_wr(5'd16, 32'h0);
    repeat (12) @(negedge clk);
    checks++;
    if (frame_count != base + n) begin
      errors++;
      $display("FAIL frame_count: got %0d frames, required %0d", frame_count - base, n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++; if (angle_ss_n_o !== 8'hFF) begin errors++; $display("FAIL reset_ss_n: got %h, required ff", angle_ss_n_o); end
    checks++; if (angle_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b, required 0", angle_sck); end
    checks++; if (angle_mosi !== 1'b1) begin errors++; $display("FAIL reset_mosi: got %b, required 1", angle_mosi); end
    checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h, required 0", avs_readdata); end
    avs_rd(5'd16, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h, required 0", d); end
    avs_rd(5'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_reg0: got %h, required 0", d); end
  endtask

  task automatic test_idle_no_mask();
    logic [31:0] d;
    int bad;
    int nz;
    int sbase;
    bad = 0; nz = 0; sbase = start_count;
    avs_wr(5'd16, 32'h0000_0001);
    repeat (1000) begin
      @(negedge clk);
      if ((angle_ss_n_o !== 8'hFF) || (angle_sck !== 1'b0)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_bus: got %0d active cycles, required 0", bad); end
    checks++; if (start_count != sbase) begin errors++; $display("FAIL idle_frames: got %0d, required 0", start_count - sbase); end
    for (int i = 0; i < 8; i++) begin
      avs_rd(5'(i), d);
      if (d !== 32'h0) nz++;
    end
    checks++; if (nz != 0) begin errors++; $display("FAIL idle_regs: got %0d nonzero, required 0", nz); end
    avs_wr(5'd3, 32'hFFFF_FFFF);
    avs_rd(5'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ignored_write: got %h, required 0", d); end
    avs_rd(5'd16, d);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL ctrl_enable: got %h, required 00000001", d); end
    avs_rd(5'd17, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped: got %h, required 0", d); end
    avs_wr(5'd16, 32'hFFFF_FFFE);
    avs_rd(5'd16, d);
    checks++; if (d !== 32'h00FF_0000) begin errors++; $display("FAIL ctrl_mask_bits: got %h, required 00ff0000", d); end
    avs_wr(5'd16, 32'h0);
    repeat (4) @(negedge clk);
    clear_logs();
  endtask

  task automatic test_good_frame();
    logic [31:0] d;
    resp[0] = 16'h9234;
    exp_sel.push_back(0);
    exp_reg.push_back(model_commit(0, resp[0]));
    run_frames(32'h0001_0001, 1);
    checks++;
    if ((sel_log.size() != 1) || (exp_sel.size() != 1)) begin
      errors++; $display("FAIL good_sel_count: got %0d frames, required 1", sel_log.size());
    end else if (sel_log.pop_front() != exp_sel.pop_front()) begin
      errors++; $display("FAIL good_sel: wrong sensor selected, required 0");
    end
    checks++; if ((len_log.size() != 1) || (len_log[0] != FRAME_LOW)) begin errors++; $display("FAIL good_len: got %0d, required %0d", (len_log.size() > 0) ? len_log[0] : -1, FRAME_LOW); end
    checks++; if ((mosi_log.size() != 1) || (mosi_log[0] !== CMD)) begin errors++; $display("FAIL good_mosi: got %h, required %h", (mosi_log.size() > 0) ? mosi_log[0] : 16'h0, CMD); end
    avs_rd(5'd0, d);
    checks++; if (d !== 32'h0101_1234) begin errors++; $display("FAIL good_reg0: got %h, required 01011234", d); end
    checks++; if (d !== exp_reg.pop_front()) begin errors++; $display("FAIL good_reg0_model: got %h, required %h", d, model_word(0)); end
    clear_logs();
  endtask

  task automatic test_bad_parity();
    logic [31:0] d;
    logic [31:0] pre;
    int t;
    resp[0] = 16'h1234;
    pre = model_word(0);
    exp_reg.push_back(model_commit(0, resp[0]));
    avs_wr(5'd16, 32'h0001_0001);
    t = 0;
    while ((angle_ss_n_o == 8'hFF) && (t < 50)) begin @(negedge clk); t++; end
    t = 0;
    while ((angle_ss_n_o != 8'hFF) && (t < 300)) begin @(negedge clk); t++; end
    checks++; if (t >= 300) begin errors++; $display("FAIL parity_frame_end: got timeout, required frame end"); end
    avs_rd(5'd0, d);
    avs_wr(5'd16, 32'h0);
    checks++; if (d !== pre) begin errors++; $display("FAIL commit_cycle_read: got %h, required %h", d, pre); end
    repeat (12) @(negedge clk);
    avs_rd(5'd0, d);
    checks++; if (d !== exp_reg.pop_front()) begin errors++; $display("FAIL parity_reg0: got %h, required %h", d, model_word(0)); end
    checks++; if (d !== 32'h0103_1234) begin errors++; $display("FAIL parity_reg0_const: got %h, required 01031234", d); end
    clear_logs();
  endtask

  task automatic test_ef_flag();
    logic [31:0] d;
    resp[0] = 16'h4000;
    exp_reg.push_back(model_commit(0, resp[0]));
    run_frames(32'h0001_0001, 1);
    avs_rd(5'd0, d);
    checks++; if (d !== exp_reg.pop_front()) begin errors++; $display("FAIL ef_reg0: got %h, required %h", d, model_word(0)); end
    clear_logs();
  endtask

  task automatic test_round_robin();
    logic [31:0] d;
    int order [9];
    int base;
    int sbase;
    int t;
    int badlen;
    int got;
    do_reset();
    resp[0] = 16'h0123; resp[2] = 16'h0457; resp[3] = 16'h3FFF; resp[5] = 16'h8001;
    order = '{0, 2, 5, 0, 2, 5, 0, 2, 3};
    for (int i = 0; i < 9; i++) begin
      exp_sel.push_back(order[i]);
      exp_reg.push_back(model_commit(order[i], resp[order[i]]));
    end
    base = frame_count; sbase = start_count;
    avs_wr(5'd16, 32'h0025_0001);
    t = 0;
    while ((start_count < sbase + 8) && (t < 2000)) begin @(negedge clk); t++; end
    repeat (20) @(negedge clk);
    avs_wr(5'd16, 32'h0008_0001);
    t = 0;
    while ((frame_count < base + 9) && (t < 1000)) begin @(negedge clk); t++; end
    avs_wr(5'd16, 32'h0);
    repeat (12) @(negedge clk);
    checks++; if (sel_log.size() != 9) begin errors++; $display("FAIL rr_count: got %0d frames, required 9", sel_log.size()); end
    for (int i = 0; i < 9; i++) begin
      got = (sel_log.size() > 0) ? sel_log.pop_front() : -1;
      checks++;
      if (got != exp_sel[i]) begin errors++; $display("FAIL rr_sel[%0d]: got %0d, required %0d", i, got, exp_sel[i]); end
    end
    badlen = 0;
    foreach (len_log[i]) if (len_log[i] != FRAME_LOW) badlen++;
    checks++; if (badlen != 0) begin errors++; $display("FAIL rr_len: got %0d bad lengths, required 0", badlen); end
    for (int i = 0; i < 8; i++) begin
      avs_rd(5'(i), d);
      checks++;
      if (d !== model_word(i)) begin errors++; $display("FAIL rr_reg[%0d]: got %h, required %h", i, d, model_word(i)); end
    end
    clear_logs();
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    int t;
    int rises;
    int nz;
    int sbase;
    logic prev;
    resp[0] = 16'h9234;
    avs_wr(5'd16, 32'h0001_0001);
    t = 0; rises = 0; prev = 1'b0;
    while ((rises < 8) && (t < 500)) begin
      @(negedge clk);
      t++;
      if (angle_sck && !prev) rises++;
      prev = angle_sck;
    end
    checks++; if ((rises != 8) || (angle_sck !== 1'b1)) begin errors++; $display("FAIL midreset_reach_bit7: got %0d rises, required 8 with sck high", rises); end
    #2 reset = 1'b1;
    #1;
    checks++; if (angle_ss_n_o !== 8'hFF) begin errors++; $display("FAIL midreset_ss_n: got %h, required ff", angle_ss_n_o); end
    checks++; if (angle_sck !== 1'b0) begin errors++; $display("FAIL midreset_sck: got %b, required 0", angle_sck); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    clear_logs();
    sbase = start_count;
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      avs_rd(5'(i), d);
      if (d !== 32'h0) nz++;
    end
    avs_rd(5'd16, d);
    if (d !== 32'h0) nz++;
    checks++; if (nz != 0) begin errors++; $display("FAIL midreset_regs: got %0d nonzero, required 0", nz); end
    repeat (300) @(negedge clk);
    checks++; if (start_count != sbase) begin errors++; $display("FAIL midreset_idle: got %0d frames, required 0", start_count - sbase); end
  endtask

  task automatic test_count_wrap();
    logic [31:0] d;
    int badsel;
    int badlen;
    resp[0] = 16'h9234;
    for (int i = 0; i < 255; i++) exp_reg.push_back(model_commit(0, resp[0]));
    run_frames(32'h0001_0001, 255);
    badsel = 0; badlen = 0;
    foreach (sel_log[i]) if (sel_log[i] != 0) badsel++;
    foreach (len_log[i]) if (len_log[i] != FRAME_LOW) badlen++;
    checks++; if ((badsel != 0) || (sel_log.size() != 255)) begin errors++; $display("FAIL wrap_sel: got %0d frames, %0d wrong sensor, required 255 and 0", sel_log.size(), badsel); end
    checks++; if (badlen != 0) begin errors++; $display("FAIL wrap_len: got %0d bad lengths, required 0", badlen); end
    avs_rd(5'd0, d);
    checks++; if (d !== exp_reg[254]) begin errors++; $display("FAIL wrap_reg0_ff: got %h, required %h", d, exp_reg[254]); end
    clear_logs();
    exp_reg.push_back(model_commit(0, resp[0]));
    run_frames(32'h0001_0001, 1);
    avs_rd(5'd0, d);
    checks++; if (d !== exp_reg.pop_front()) begin errors++; $display("FAIL wrap_reg0_00: got %h, required %h", d, model_word(0)); end
    checks++; if (d !== 32'h0001_1234) begin errors++; $display("FAIL wrap_reg0_const: got %h, required 00011234", d); end
    clear_logs();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) resp[i] = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle_no_mask();
    test_good_frame();
    test_bad_parity();
    test_ef_flag();
    test_round_robin();
    test_reset_mid_frame();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
